// File: rtl/stall_control_pkg.sv
// Shared encodings for the pipeline interlock: instruction field positions,
// opcode / ALU-op constants, the nop word and the multdiv FSM state type.
package stall_control_pkg;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_BNE   = 5'd2;
  localparam logic [4:0] OP_JR    = 5'd4;
  localparam logic [4:0] OP_ADDI  = 5'd5;
  localparam logic [4:0] OP_BLT   = 5'd6;
  localparam logic [4:0] OP_SW    = 5'd7;
  localparam logic [4:0] OP_LW    = 5'd8;

  localparam logic [4:0] ALU_MUL  = 5'd6;
  localparam logic [4:0] ALU_DIV  = 5'd7;

  localparam logic [31:0] NOP_IR  = 32'h0000_0000;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/stall_control_if.sv
// Bundle between the pipeline datapath (master) and the interlock unit (slave).
interface stall_control_if #(
  parameter int CNT_W = 32
);

  logic [31:0]      fd_ir;
  logic [31:0]      dx_ir;
  logic             branch_taken;
  logic             multdiv_ready;
  logic             multdiv_exception;

  logic             pc_enable;
  logic             fd_enable;
  logic             dx_nop;
  logic             xm_nop;
  logic             fd_flush;
  logic             multdiv_start;
  logic             md_busy;
  logic             md_error;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output fd_ir, dx_ir, branch_taken, multdiv_ready, multdiv_exception,
    input  pc_enable, fd_enable, dx_nop, xm_nop, fd_flush,
           multdiv_start, md_busy, md_error, stall_count
  );

  modport slave (
    input  fd_ir, dx_ir, branch_taken, multdiv_ready, multdiv_exception,
    output pc_enable, fd_enable, dx_nop, xm_nop, fd_flush,
           multdiv_start, md_busy, md_error, stall_count
  );

endinterface

// File: rtl/stall_control_load_use_detect.sv
// Combinational load-use hazard compare between the lw in DX and the
// instruction in FD. Only source registers that would be read in X count;
// a sw whose data register alone matches is served by the MW->XM bypass.
module load_use_detect
  import stall_control_pkg::*;
(
  input  logic [4:0] dx_op_i,
  input  logic [4:0] dx_rd_i,
  input  logic [4:0] fd_op_i,
  input  logic [4:0] fd_rd_i,
  input  logic [4:0] fd_rs_i,
  input  logic [4:0] fd_rt_i,
  output logic       hazard_o
);

  // Per-opcode source-register match against the load destination.
  always_comb begin
    hazard_o = 1'b0;
    if (dx_op_i == OP_LW && dx_rd_i != 5'd0) begin
      case (fd_op_i)
        OP_RTYPE:               hazard_o = (fd_rs_i == dx_rd_i) || (fd_rt_i == dx_rd_i);
        OP_ADDI, OP_SW, OP_LW:  hazard_o = (fd_rs_i == dx_rd_i);
        OP_BNE, OP_BLT:         hazard_o = (fd_rd_i == dx_rd_i) || (fd_rs_i == dx_rd_i);
        OP_JR:                  hazard_o = (fd_rd_i == dx_rd_i);
        default:                hazard_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/stall_control.sv
// Pipeline interlock: load-use stall, multdiv occupancy FSM with start/ready
// handshake and timeout, branch flush, and a stall-cycle counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// MD_IDLE | no multdiv in flight; a mul/div in DX issues start and stalls
// MD_BUSY | waiting for multdiv_ready or timeout; pipeline held, XM gets nop
// MD_DONE | result ready; stall released so the mul/div advances to XM
module stall_control
  import stall_control_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  stall_control_if.slave  bus
);

  localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MD_TIMEOUT - 1);

  md_state_t        state_q;
  logic [TW-1:0]    md_cnt_q;
  logic             md_error_q;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  logic [4:0] dx_op, dx_rd, dx_alu;
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic       dx_is_md;
  logic       lu_hazard;
  logic       md_start;
  logic       md_stall;
  logic       lu_stall;
  logic       br_flush;
  logic       pc_en;

  // Fields the interlock never consults; kept visible so lint sees them sunk.
  logic       unused_ir_bits;
  assign unused_ir_bits = ^{bus.fd_ir[11:0], bus.dx_ir[21:7], bus.dx_ir[1:0]};

  assign dx_op  = bus.dx_ir[OP_HI:OP_LO];
  assign dx_rd  = bus.dx_ir[RD_HI:RD_LO];
  assign dx_alu = bus.dx_ir[ALU_HI:ALU_LO];
  assign fd_op  = bus.fd_ir[OP_HI:OP_LO];
  assign fd_rd  = bus.fd_ir[RD_HI:RD_LO];
  assign fd_rs  = bus.fd_ir[RS_HI:RS_LO];
  assign fd_rt  = bus.fd_ir[RT_HI:RT_LO];

  assign dx_is_md = (dx_op == OP_RTYPE) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));

  load_use_detect u_load_use_detect (
    .dx_op_i  (dx_op),
    .dx_rd_i  (dx_rd),
    .fd_op_i  (fd_op),
    .fd_rd_i  (fd_rd),
    .fd_rs_i  (fd_rs),
    .fd_rt_i  (fd_rt),
    .hazard_o (lu_hazard)
  );

  // Stall/flush resolution; everything is forced to idle values while reset_n is low.
  // Multdiv outranks both load-use and flush; a taken branch overrides load-use.
  always_comb begin
    md_start = reset_n && (state_q == MD_IDLE) && dx_is_md;
    md_stall = reset_n && (md_start || (state_q == MD_BUSY));
    lu_stall = reset_n && lu_hazard && !md_stall && !bus.branch_taken;
    br_flush = reset_n && bus.branch_taken && !md_stall;
    pc_en    = !(md_stall || lu_stall);
  end

  assign bus.pc_enable     = pc_en;
  assign bus.fd_enable     = pc_en;
  assign bus.dx_nop        = lu_stall || br_flush;
  assign bus.xm_nop        = md_stall;
  assign bus.fd_flush      = br_flush;
  assign bus.multdiv_start = md_start;
  assign bus.md_busy       = (state_q != MD_IDLE);
  assign bus.md_error      = md_error_q;
  assign bus.stall_count   = stall_count_q;

  // Multdiv occupancy FSM with timeout counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= MD_IDLE;
      md_cnt_q   <= '0;
      md_error_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (dx_is_md) begin
            state_q    <= MD_BUSY;
            md_cnt_q   <= '0;
            md_error_q <= 1'b0;
          end
        end
        MD_BUSY: begin
          if (bus.multdiv_ready) begin
            state_q    <= MD_DONE;
            md_error_q <= bus.multdiv_exception;
          end else if (md_cnt_q == TIMEOUT_LAST) begin
            state_q    <= MD_DONE;
            md_error_q <= 1'b1;
          end else begin
            md_cnt_q   <= md_cnt_q + TW'(1);
          end
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_en) stall_count_d = stall_count_q + CNT_W'(1);
  end

  // Stall-cycle performance counter, wraps naturally.
  always_ff @(posedge clock) begin
    if (!reset_n) stall_count_q <= '0;
    else          stall_count_q <= stall_count_d;
  end

endmodule

// File: tb/tb_stall_control.sv
// Directed bench for stall_control: inputs driven on the falling edge,
// outputs sampled 1 time unit later, expected values hand-computed.
module tb_stall_control;
  import stall_control_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  stall_control_if #(.CNT_W(32)) bus ();

  stall_control #(.MD_TIMEOUT(40), .CNT_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  // {pc_enable, fd_enable, dx_nop, xm_nop, fd_flush, multdiv_start, md_busy, md_error}
  logic [7:0] ctl;
  assign ctl = {bus.pc_enable, bus.fd_enable, bus.dx_nop, bus.xm_nop,
                bus.fd_flush, bus.multdiv_start, bus.md_busy, bus.md_error};

  localparam logic [7:0] C_IDLE  = 8'b1100_0000;
  localparam logic [7:0] C_LU    = 8'b0010_0000;
  localparam logic [7:0] C_BR    = 8'b1110_1000;
  localparam logic [7:0] C_START = 8'b0001_0100;
  localparam logic [7:0] C_BUSY  = 8'b0001_0010;
  localparam logic [7:0] C_DONE  = 8'b1100_0010;

  function automatic logic [31:0] r_ins(input logic [4:0] rd, rs, rt, alu);
    return {OP_RTYPE, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  logic [31:0] LW3, ADD533, MUL, DIV;

  task automatic drive(input logic rst, input logic [31:0] dx, fd,
                       input logic br, rdy, exc);
    @(negedge clock);
    reset_n               = rst;
    bus.dx_ir             = dx;
    bus.fd_ir             = fd;
    bus.branch_taken      = br;
    bus.multdiv_ready     = rdy;
    bus.multdiv_exception = exc;
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, MUL, NOP_IR, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL reset_ctl_mul_in_dx: got %b expected %b", ctl, C_IDLE);
    end
    drive(1'b0, NOP_IR, NOP_IR, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (bus.stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", bus.stall_count);
    end
  endtask

  task automatic test_load_use;
    drive(1'b1, LW3, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_LU) begin
      errors++; $display("FAIL lu_stall: got %b expected %b", ctl, C_LU);
    end
    checks++;
    if (bus.stall_count !== exp_cnt) begin
      errors++; $display("FAIL lu_count_before: got %0d expected %0d", bus.stall_count, exp_cnt);
    end
    exp_cnt++;
    // lw moved on to XM, DX holds the inserted nop, FD still holds the add
    drive(1'b1, NOP_IR, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL lu_release: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (bus.stall_count !== exp_cnt) begin
      errors++; $display("FAIL lu_count_after: got %0d expected %0d", bus.stall_count, exp_cnt);
    end
  endtask

  typedef struct {
    logic [31:0] dx;
    logic [31:0] fd;
    logic        br;
    logic [7:0]  ctl;
  } vec_t;

  task automatic test_hazard_table;
    vec_t v[16];
    v[0]  = '{LW3, i_ins(OP_SW, 5'd3, 5'd6, 17'd0), 1'b0, C_IDLE};     // sw data reg only
    v[1]  = '{i_ins(OP_LW, 5'd0, 5'd1, 17'd0), r_ins(5'd1, 5'd0, 5'd0, 5'd0), 1'b0, C_IDLE}; // r0
    v[2]  = '{LW3, i_ins(OP_SW, 5'd5, 5'd3, 17'd0), 1'b0, C_LU};       // sw base reg
    v[3]  = '{LW3, i_ins(OP_ADDI, 5'd4, 5'd3, 17'd1), 1'b0, C_LU};
    v[4]  = '{LW3, i_ins(OP_LW, 5'd4, 5'd3, 17'd0), 1'b0, C_LU};
    v[5]  = '{LW3, i_ins(OP_BNE, 5'd3, 5'd7, 17'd0), 1'b0, C_LU};      // bne rd match
    v[6]  = '{LW3, i_ins(OP_BLT, 5'd7, 5'd3, 17'd0), 1'b0, C_LU};      // blt rs match
    v[7]  = '{LW3, i_ins(OP_JR, 5'd3, 5'd0, 17'd0), 1'b0, C_LU};
    v[8]  = '{LW3, i_ins(OP_JR, 5'd9, 5'd3, 17'd0), 1'b0, C_IDLE};     // jr ignores rs
    v[9]  = '{LW3, r_ins(5'd5, 5'd4, 5'd3, 5'd0), 1'b0, C_LU};         // rt match
    v[10] = '{LW3, i_ins(OP_ADDI, 5'd4, 5'd1, 17'h03000), 1'b0, C_IDLE}; // imm bits look like rt=3
    v[11] = '{i_ins(OP_ADDI, 5'd3, 5'd0, 17'd0), ADD533, 1'b0, C_IDLE}; // not a load
    v[12] = '{LW3, ADD533, 1'b1, C_BR};                                 // branch overrides load-use
    v[13] = '{NOP_IR, NOP_IR, 1'b1, C_BR};
    v[14] = '{LW3, r_ins(5'd3, 5'd1, 5'd2, 5'd0), 1'b0, C_IDLE};       // rtype rd match only
    v[15] = '{LW3, r_ins(5'd6, 5'd3, 5'd4, ALU_MUL), 1'b0, C_LU};      // mul in FD reads r3
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, v[i].dx, v[i].fd, v[i].br, 1'b0, 1'b0);
      checks++;
      if (ctl !== v[i].ctl) begin
        errors++; $display("FAIL hazard_vec%0d: got %b expected %b", i, ctl, v[i].ctl);
      end
      if (v[i].ctl[7] == 1'b0) exp_cnt++;
    end
    drive(1'b1, NOP_IR, NOP_IR, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.stall_count !== exp_cnt) begin
      errors++; $display("FAIL hazard_count: got %0d expected %0d", bus.stall_count, exp_cnt);
    end
  endtask

  task automatic test_mul_ready;
    drive(1'b1, MUL, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_START) begin
      errors++; $display("FAIL mul_start: got %b expected %b", ctl, C_START);
    end
    exp_cnt++;
    // ready in the 17th busy cycle; branch_taken in cycle 4 must be ignored
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, MUL, ADD533, (k == 4), (k == 17), 1'b0);
      checks++;
      if (ctl !== C_BUSY) begin
        errors++; $display("FAIL mul_busy_c%0d: got %b expected %b", k, ctl, C_BUSY);
      end
      exp_cnt++;
    end
    drive(1'b1, MUL, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_DONE) begin
      errors++; $display("FAIL mul_done: got %b expected %b", ctl, C_DONE);
    end
    checks++;
    if (bus.stall_count !== exp_cnt) begin
      errors++; $display("FAIL mul_count: got %0d expected %0d", bus.stall_count, exp_cnt);
    end
    drive(1'b1, NOP_IR, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL mul_idle: got %b expected %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_div_exception;
    drive(1'b1, DIV, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_START) begin
      errors++; $display("FAIL div_start: got %b expected %b", ctl, C_START);
    end
    exp_cnt++;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, DIV, ADD533, 1'b0, (k == 5), (k == 5));
      checks++;
      if (ctl !== C_BUSY) begin
        errors++; $display("FAIL div_busy_c%0d: got %b expected %b", k, ctl, C_BUSY);
      end
      exp_cnt++;
    end
    drive(1'b1, DIV, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== (C_DONE | 8'b1)) begin
      errors++; $display("FAIL div_done_err: got %b expected %b", ctl, C_DONE | 8'b1);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, NOP_IR, ADD533, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== (C_IDLE | 8'b1)) begin
        errors++; $display("FAIL div_err_held%0d: got %b expected %b", k, ctl, C_IDLE | 8'b1);
      end
    end
  endtask

  task automatic test_timeout;
    // md_error from the div still held during the start cycle
    drive(1'b1, MUL, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== (C_START | 8'b1)) begin
      errors++; $display("FAIL to_start: got %b expected %b", ctl, C_START | 8'b1);
    end
    exp_cnt++;
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, MUL, ADD533, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== C_BUSY) begin
        errors++; $display("FAIL to_busy_c%0d: got %b expected %b", k, ctl, C_BUSY);
      end
      exp_cnt++;
    end
    drive(1'b1, MUL, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== (C_DONE | 8'b1)) begin
      errors++; $display("FAIL to_done: got %b expected %b", ctl, C_DONE | 8'b1);
    end
    drive(1'b1, NOP_IR, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== (C_IDLE | 8'b1)) begin
      errors++; $display("FAIL to_idle: got %b expected %b", ctl, C_IDLE | 8'b1);
    end
    checks++;
    if (bus.stall_count !== exp_cnt) begin
      errors++; $display("FAIL to_count: got %0d expected %0d", bus.stall_count, exp_cnt);
    end
  endtask

  task automatic test_reset_busy;
    drive(1'b1, MUL, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== (C_START | 8'b1)) begin
      errors++; $display("FAIL rb_start: got %b expected %b", ctl, C_START | 8'b1);
    end
    exp_cnt++;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, MUL, ADD533, 1'b0, 1'b0, 1'b0);
      exp_cnt++;
    end
    checks++;
    if (bus.stall_count !== exp_cnt - 32'd1) begin
      errors++; $display("FAIL rb_count_busy: got %0d expected %0d", bus.stall_count, exp_cnt - 32'd1);
    end
    // reset low mid-BUSY: comb outputs idle at once, md_busy still registered 1
    drive(1'b0, MUL, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== 8'b1100_0010) begin
      errors++; $display("FAIL rb_reset_comb: got %b expected %b", ctl, 8'b1100_0010);
    end
    drive(1'b0, NOP_IR, ADD533, 1'b0, 1'b0, 1'b0);
    exp_cnt = 32'd0;
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL rb_after_reset: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (bus.stall_count !== exp_cnt) begin
      errors++; $display("FAIL rb_count_cleared: got %0d expected 0", bus.stall_count);
    end
    drive(1'b1, NOP_IR, ADD533, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL rb_late_ready: got %b expected %b", ctl, C_IDLE);
    end
    drive(1'b1, NOP_IR, ADD533, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL rb_late_ready_after: got %b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (bus.stall_count !== exp_cnt) begin
      errors++; $display("FAIL rb_count_final: got %0d expected 0", bus.stall_count);
    end
  endtask

  initial begin
    LW3    = i_ins(OP_LW, 5'd3, 5'd1, 17'd0);
    ADD533 = r_ins(5'd5, 5'd3, 5'd4, 5'd0);
    MUL    = r_ins(5'd5, 5'd1, 5'd2, ALU_MUL);
    DIV    = r_ins(5'd6, 5'd1, 5'd2, ALU_DIV);
    reset_n               = 1'b0;
    bus.dx_ir             = NOP_IR;
    bus.fd_ir             = NOP_IR;
    bus.branch_taken      = 1'b0;
    bus.multdiv_ready     = 1'b0;
    bus.multdiv_exception = 1'b0;

    test_reset();
    test_load_use();
    test_hazard_table();
    test_mul_ready();
    test_div_exception();
    test_timeout();
    test_reset_busy();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
